redmule_mesh_sync_ctrl: RTL and testbench
=========================================

Name: redmule_mesh_sync_ctrl

Overview:
Mesh-level launch and barrier controller for the RedMulE tile array. It sequences per-tile tile_enable and fetch_enable with a staggered start, then watches per-tile core_sleep to detect global barriers. At each barrier it either pulses per-tile wu_wfe to release the cores or ends the run. It sits beside the tile array in redmule_mesh and replaces the shared, static tile_enable, fetch_enable and wu_wfe nets.

Parameters:
N_TILES, 4, number of tiles controlled
STAGGER_CYCLES, 2, cycles between successive fetch_enable assertions (>=1)
WAKE_GUARD, 2, cycles after a wake pulse during which core_sleep is ignored
TIMEOUT_W, 16, width of the barrier timeout counter

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
start_i  in  1  start request; accepted only in IDLE
abort_i  in  1  abort the current run
tile_mask_i  in  N_TILES  tiles taking part; latched at start
num_barriers_i  in  16  number of wake barriers before completion; latched at start
timeout_i  in  TIMEOUT_W  max cycles in RUN without a barrier; 0 disables; latched at start
core_sleep_i  in  N_TILES  per-tile core sleep status
tile_enable_o  out  N_TILES  per-tile enable
fetch_enable_o  out  N_TILES  per-tile fetch enable
wu_wfe_o  out  N_TILES  per-tile wake-up pulse
busy_o  out  1  high when not in IDLE
done_o  out  1  one-cycle completion pulse
timeout_o  out  1  sticky timeout flag
barrier_count_o  out  16  wake pulses issued in the current run

Behaviour:
- Reset (async, rst_i=1): state IDLE; all outputs 0, including timeout_o and barrier_count_o; all latches cleared.
- States: IDLE, ENABLE, LAUNCH, RUN, WAKE, GUARD.
- IDLE:
  - start_i=1 latches mask, num_barriers and timeout; clears timeout_o and barrier_count_o.
  - If the latched mask is 0: done_o pulses next cycle, no enables assert, stay IDLE.
  - Otherwise go to ENABLE.
  - start_i in any other state is ignored.
- ENABLE (1 cycle): tile_enable_o = mask, held until the run leaves RUN/WAKE/GUARD.
- LAUNCH:
  - Masked tiles get fetch_enable_o set in ascending index order, one every STAGGER_CYCLES. Unmasked indices are skipped and cost no cycles.
  - First set is the cycle after ENABLE; each bit stays high once set.
  - The cycle after the last bit is set, go to RUN; the cycle counter is cleared.
- RUN:
  - A barrier requires (core_sleep_i & mask) == mask on 2 consecutive cycles. A single-cycle all-sleep is not a barrier.
  - On barrier detection at cycle t, the action happens at t+1:
    - if barrier_count_o == num_barriers: done_o pulses 1 cycle, tile_enable_o and fetch_enable_o drop to 0 at t+1, go to IDLE;
    - else: WAKE.
  - Cycle counter increments each RUN cycle and saturates. If timeout != 0 and counter == timeout: timeout_o=1, enables drop next cycle, go to IDLE, no done_o.
  - Barrier detection and timeout in the same cycle: barrier wins.
- WAKE (1 cycle): wu_wfe_o = mask; barrier_count_o increments (saturates at 0xFFFF).
- GUARD: WAKE_GUARD cycles with core_sleep ignored and the sleep-history register cleared, then back to RUN with the cycle counter cleared.
- abort_i=1 in any non-IDLE state: next cycle is IDLE, all enables and wu_wfe drop to 0, no done_o, timeout_o unchanged. abort_i has priority over every other event.
- wu_wfe_o and done_o are never high outside WAKE and the completion cycle. Unmasked bits of every per-tile output are always 0.

Test Plan (N_TILES=4, STAGGER_CYCLES=2, WAKE_GUARD=2; start_i pulsed at cycle 0):
- mask=4'b1111, num_barriers=0, timeout=0:
  - tile_enable_o=1111 at cycle 1; fetch_enable_o bits 0..3 rise at cycles 2, 4, 6, 8; RUN from cycle 9.
  - core_sleep_i=1111 from cycle 20 -> done_o at cycle 22, all enables 0 at cycle 22, busy_o low at cycle 23.
- mask=4'b1010, num_barriers=2:
  - fetch_enable_o bit1 rises at cycle 2, bit3 at cycle 4.
  - Three all-sleep episodes -> wu_wfe_o=1010 pulses twice; barrier_count_o=2; done_o after the third episode.
  - Bits 0 and 2 of all per-tile outputs stay 0 throughout.
- mask=4'b1111, timeout=100, core_sleep_i held 0 -> timeout_o=1 at RUN entry +100 cycles, enables 0 the next cycle, no done_o. A new start clears timeout_o.
- abort_i at cycle 5 (mid-LAUNCH) -> cycle 6 all outputs 0 except barrier_count_o; IDLE; a second start behaves as the first scenario.
- mask=0 -> done_o at cycle 1, tile_enable_o stays 0000.
- core_sleep_i=1111 for 1 cycle only, then 0 -> no wu_wfe_o and no done_o. Sleep asserted during GUARD is ignored.

Source files
------------

// File: rtl/redmule_mesh_sync_ctrl.sv
// Mesh-level launch and barrier controller for the RedMulE tile array.
// Raises tile_enable for the participating tiles, staggers fetch_enable one
// tile at a time, then watches core_sleep for global barriers. Each barrier
// either pulses wu_wfe to release the cores or, after the requested number
// of wake-ups, completes the run. A per-RUN cycle counter bounds how long
// the mesh may go without reaching a barrier.
module redmule_mesh_sync_ctrl #(
  parameter int unsigned N_TILES        = 4,
  parameter int unsigned STAGGER_CYCLES = 2,
  parameter int unsigned WAKE_GUARD     = 2,
  parameter int unsigned TIMEOUT_W      = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [N_TILES-1:0]   tile_mask_i,
  input  logic [15:0]          num_barriers_i,
  input  logic [TIMEOUT_W-1:0] timeout_i,
  input  logic [N_TILES-1:0]   core_sleep_i,
  output logic [N_TILES-1:0]   tile_enable_o,
  output logic [N_TILES-1:0]   fetch_enable_o,
  output logic [N_TILES-1:0]   wu_wfe_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 timeout_o,
  output logic [15:0]          barrier_count_o
);

  // One down-counter is shared by the launch stagger and the wake guard.
  localparam int unsigned STEP_MAX = (STAGGER_CYCLES > WAKE_GUARD) ? STAGGER_CYCLES : WAKE_GUARD;
  localparam int unsigned STEP_W   = (STEP_MAX > 1) ? $clog2(STEP_MAX) : 1;
  localparam logic [STEP_W-1:0] STAGGER_RELOAD = STEP_W'(STAGGER_CYCLES - 1);
  localparam logic [STEP_W-1:0] GUARD_RELOAD   = STEP_W'((WAKE_GUARD > 0) ? WAKE_GUARD - 1 : 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENABLE,
    ST_LAUNCH,
    ST_RUN,
    ST_WAKE,
    ST_GUARD
  } state_e;

  state_e               state_q;
  logic [N_TILES-1:0]   mask_q;
  logic [15:0]          num_barriers_q;
  logic [TIMEOUT_W-1:0] timeout_q;
  logic [TIMEOUT_W-1:0] run_cnt_q;
  logic [STEP_W-1:0]    step_cnt_q;
  logic                 sleep_prev_q;

  logic                 all_sleep;
  logic                 barrier;
  logic [N_TILES-1:0]   pending;
  logic [N_TILES-1:0]   next_bit;
  logic [TIMEOUT_W-1:0] run_cnt_inc;
  logic                 timeout_hit;
  logic [15:0]          barrier_count_inc;

  // Barrier = every participating core asleep on two consecutive RUN cycles.
  assign all_sleep = ((core_sleep_i & mask_q) == mask_q);
  assign barrier   = all_sleep && sleep_prev_q;

  // Lowest participating tile whose fetch_enable is not yet raised.
  assign pending  = mask_q & ~fetch_enable_o;
  assign next_bit = pending & (~pending + N_TILES'(1));

  // run_cnt_inc counts the current RUN cycle, so a timeout of T commits on
  // the T-th RUN cycle and the enables drop one cycle after timeout_o rises.
  assign run_cnt_inc       = (run_cnt_q == '1) ? run_cnt_q : run_cnt_q + TIMEOUT_W'(1);
  assign timeout_hit       = (timeout_q != '0) && (run_cnt_inc == timeout_q);
  assign barrier_count_inc = (barrier_count_o == 16'hFFFF) ? barrier_count_o
                                                           : barrier_count_o + 16'd1;

  // Launch/barrier sequencer with all outputs registered.
  // NOTE: every register here is assigned with <= so all of them update from
  // the same pre-edge values, regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= ST_IDLE;
      mask_q          <= '0;
      num_barriers_q  <= '0;
      timeout_q       <= '0;
      run_cnt_q       <= '0;
      step_cnt_q      <= '0;
      sleep_prev_q    <= 1'b0;
      tile_enable_o   <= '0;
      fetch_enable_o  <= '0;
      wu_wfe_o        <= '0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      timeout_o       <= 1'b0;
      barrier_count_o <= '0;
    end else begin
      // NOTE: the pulse outputs default low every cycle, so only the branch
      // that wants a pulse has to mention them.
      wu_wfe_o <= '0;
      done_o   <= 1'b0;

      if (abort_i && (state_q != ST_IDLE)) begin
        state_q        <= ST_IDLE;
        tile_enable_o  <= '0;
        fetch_enable_o <= '0;
        busy_o         <= 1'b0;
        sleep_prev_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            // busy_o stays high through a completion pulse and drops here.
            busy_o <= 1'b0;
            if (start_i) begin
              mask_q          <= tile_mask_i;
              num_barriers_q  <= num_barriers_i;
              timeout_q       <= timeout_i;
              timeout_o       <= 1'b0;
              barrier_count_o <= '0;
              if (tile_mask_i == '0) begin
                done_o <= 1'b1;
              end else begin
                state_q       <= ST_ENABLE;
                tile_enable_o <= tile_mask_i;
                busy_o        <= 1'b1;
              end
            end
          end

          ST_ENABLE: begin
            fetch_enable_o <= fetch_enable_o | next_bit;
            step_cnt_q     <= STAGGER_RELOAD;
            state_q        <= ST_LAUNCH;
          end

          ST_LAUNCH: begin
            sleep_prev_q <= 1'b0;
            if (pending == '0) begin
              state_q   <= ST_RUN;
              run_cnt_q <= '0;
            end else if (step_cnt_q == '0) begin
              fetch_enable_o <= fetch_enable_o | next_bit;
              step_cnt_q     <= STAGGER_RELOAD;
            end else begin
              step_cnt_q <= step_cnt_q - STEP_W'(1);
            end
          end

          ST_RUN: begin
            run_cnt_q    <= run_cnt_inc;
            sleep_prev_q <= all_sleep;
            if (timeout_o) begin
              // Timeout committed last cycle: shut the mesh down now.
              state_q        <= ST_IDLE;
              tile_enable_o  <= '0;
              fetch_enable_o <= '0;
              busy_o         <= 1'b0;
            end else if (barrier) begin
              if (barrier_count_o == num_barriers_q) begin
                state_q        <= ST_IDLE;
                tile_enable_o  <= '0;
                fetch_enable_o <= '0;
                done_o         <= 1'b1;
              end else begin
                state_q         <= ST_WAKE;
                wu_wfe_o        <= mask_q;
                barrier_count_o <= barrier_count_inc;
              end
            end else if (timeout_hit) begin
              timeout_o <= 1'b1;
            end
          end

          ST_WAKE: begin
            sleep_prev_q <= 1'b0;
            if (WAKE_GUARD == 0) begin
              state_q   <= ST_RUN;
              run_cnt_q <= '0;
            end else begin
              state_q    <= ST_GUARD;
              step_cnt_q <= GUARD_RELOAD;
            end
          end

          ST_GUARD: begin
            // Cores are still waking up; their sleep status is meaningless.
            sleep_prev_q <= 1'b0;
            if (step_cnt_q == '0) begin
              state_q   <= ST_RUN;
              run_cnt_q <= '0;
            end else begin
              step_cnt_q <= step_cnt_q - STEP_W'(1);
            end
          end

          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_redmule_mesh_sync_ctrl.sv
// Self-checking bench for redmule_mesh_sync_ctrl: directed table and corner
// sequences with fixed expectations, then random traffic compared cycle by
// cycle against a timeline-based reference model.
module tb_redmule_mesh_sync_ctrl;

  localparam int N   = 4;
  localparam int STG = 2;
  localparam int WG  = 2;
  localparam int TW  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [N-1:0]  mask;
  logic [15:0]   nb;
  logic [TW-1:0] tmo;
  logic [N-1:0]  sleep;
  logic [N-1:0]  te;
  logic [N-1:0]  fe;
  logic [N-1:0]  wu;
  logic          busy;
  logic          done;
  logic          tmo_flag;
  logic [15:0]   bcnt;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  redmule_mesh_sync_ctrl #(
    .N_TILES(N), .STAGGER_CYCLES(STG), .WAKE_GUARD(WG), .TIMEOUT_W(TW)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start),
    .abort_i        (abort),
    .tile_mask_i    (mask),
    .num_barriers_i (nb),
    .timeout_i      (tmo),
    .core_sleep_i   (sleep),
    .tile_enable_o  (te),
    .fetch_enable_o (fe),
    .wu_wfe_o       (wu),
    .busy_o         (busy),
    .done_o         (done),
    .timeout_o      (tmo_flag),
    .barrier_count_o(bcnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (timeline based) ----------------
  bit            model_on = 1'b0;
  bit            m_active, m_tmo_hit;
  int            m_s, m_run_from, m_streak, m_runlen;
  logic [N-1:0]  m_mask;
  logic [15:0]   m_nb;
  logic [TW-1:0] m_tmo;
  logic [N-1:0]  e_te, e_fe, e_wu;
  logic          e_busy, e_done, e_tmo;
  logic [15:0]   e_cnt;

  // Cycle on which tile idx gets fetch_enable, for a run started at cycle s.
  function automatic int rise_cycle(int s, logic [N-1:0] msk, int idx);
    int rank = 0;
    for (int j = 0; j < idx; j++) if (msk[j]) rank++;
    return s + 2 + rank * STG;
  endfunction

  task model_reset();
    m_active = 0; m_tmo_hit = 0; m_streak = 0; m_runlen = 0;
    m_s = 0; m_run_from = 0; m_mask = '0; m_nb = '0; m_tmo = '0;
    e_te = '0; e_fe = '0; e_wu = '0; e_busy = 0; e_done = 0; e_tmo = 0; e_cnt = '0;
  endtask

  // Given the inputs applied during cycle cyc, compute outputs for cyc+1.
  task model_step();
    int c;
    bit all_sl;
    c = cyc;
    e_wu = '0;
    e_done = 0;
    if (!m_active) begin
      e_busy = 0;
      if (start) begin
        m_mask = mask; m_nb = nb; m_tmo = tmo;
        e_tmo = 0; e_cnt = '0; m_tmo_hit = 0;
        if (mask == '0) e_done = 1;
        else begin
          m_active   = 1;
          m_s        = c;
          m_run_from = c + 2 + ($countones(mask) - 1) * STG + 1;
          m_streak   = 0;
          m_runlen   = 0;
          e_busy     = 1;
          e_te       = mask;
          e_fe       = '0;
        end
      end
    end else if (abort) begin
      m_active = 0; e_te = '0; e_fe = '0; e_busy = 0;
    end else if (c < m_run_from) begin
      // enable, launch, wake or guard: no sleep tracking
      m_streak = 0;
      m_runlen = 0;
      for (int i = 0; i < N; i++)
        if (m_mask[i] && (c + 1 >= rise_cycle(m_s, m_mask, i))) e_fe[i] = 1'b1;
    end else begin
      all_sl   = ((sleep & m_mask) == m_mask);
      m_streak = all_sl ? m_streak + 1 : 0;
      if (m_runlen < (1 << TW) - 1) m_runlen++;
      if (m_tmo_hit) begin
        m_active = 0; e_te = '0; e_fe = '0; e_busy = 0;
      end else if (m_streak >= 2) begin
        if (e_cnt == m_nb) begin
          e_done = 1; e_te = '0; e_fe = '0; m_active = 0;
        end else begin
          e_wu = m_mask;
          if (e_cnt != 16'hFFFF) e_cnt++;
          m_run_from = c + 2 + WG;
        end
      end else if ((m_tmo != '0) && (m_runlen == int'(m_tmo))) begin
        e_tmo = 1; m_tmo_hit = 1;
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task tick();
    if (model_on) model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task go(input logic [N-1:0] m, input logic [15:0] n, input logic [TW-1:0] t);
    mask = m; nb = n; tmo = t; start = 1'b1;
    cyc = 0;
    tick();
    start = 1'b0;
  endtask

  logic [N-1:0] mon_mask;
  int wu_pulses, wu_bad, done_cnt, unmasked_bad;

  task mon_clear(input logic [N-1:0] m);
    mon_mask = m; wu_pulses = 0; wu_bad = 0; done_cnt = 0; unmasked_bad = 0;
  endtask

  task mon_tick();
    tick();
    if (wu != '0) begin
      wu_pulses++;
      if (wu != mon_mask) wu_bad++;
    end
    if (done) done_cnt++;
    if (((te | fe | wu) & ~mon_mask) != '0) unmasked_bad++;
  endtask

  typedef struct {
    int           cyc;
    logic [N-1:0] sleep;
    logic [N-1:0] te;
    logic [N-1:0] fe;
    logic         busy;
    logic         done;
  } vec_t;

  vec_t tbl[11];

  // Full-mask launch, one barrier, completion.
  task run_table();
    int idx;
    idx = 0;
    sleep = '0;
    go(4'hF, 16'd0, '0);
    while (cyc <= 23) begin
      if ((idx < 11) && (tbl[idx].cyc == cyc)) begin
        check("tbl_te",   te,   tbl[idx].te);
        check("tbl_fe",   fe,   tbl[idx].fe);
        check("tbl_wu",   wu,   '0);
        check("tbl_busy", busy, tbl[idx].busy);
        check("tbl_done", done, tbl[idx].done);
        sleep = tbl[idx].sleep;
        idx++;
      end
      tick();
    end
  endtask

  int sleep_hold;

  initial begin
    //            cyc sleep   te    fe   busy done
    tbl[0]  = '{ 1, 4'h0, 4'hF, 4'h0, 1'b1, 1'b0};
    tbl[1]  = '{ 2, 4'h0, 4'hF, 4'h1, 1'b1, 1'b0};
    tbl[2]  = '{ 3, 4'h0, 4'hF, 4'h1, 1'b1, 1'b0};
    tbl[3]  = '{ 4, 4'h0, 4'hF, 4'h3, 1'b1, 1'b0};
    tbl[4]  = '{ 6, 4'h0, 4'hF, 4'h7, 1'b1, 1'b0};
    tbl[5]  = '{ 8, 4'h0, 4'hF, 4'hF, 1'b1, 1'b0};
    tbl[6]  = '{ 9, 4'h0, 4'hF, 4'hF, 1'b1, 1'b0};
    tbl[7]  = '{20, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0};
    tbl[8]  = '{21, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0};
    tbl[9]  = '{22, 4'hF, 4'h0, 4'h0, 1'b1, 1'b1};
    tbl[10] = '{23, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; abort = 1'b0; mask = '0; nb = '0; tmo = '0; sleep = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_outputs", {te, fe, wu, busy, done, tmo_flag, bcnt}, '0);
    rst = 1'b0;
    tick();
    check("idle_busy", busy, 1'b0);

    // Scenario A: directed table.
    run_table();

    // Scenario B: sparse mask, two wake barriers, completion on the third.
    go(4'b1010, 16'd2, '0);
    check("b_te", te, 4'b1010);
    tick(); check("b_fe_c2", fe, 4'b0010);
    tick(); check("b_fe_c3", fe, 4'b0010);
    tick(); check("b_fe_c4", fe, 4'b1010);
    mon_clear(4'b1010);
    mon_tick(); mon_tick();
    for (int ep = 0; ep < 3; ep++) begin
      sleep = 4'b1110;
      mon_tick(); mon_tick();
      sleep = 4'b0000;
      repeat (6) mon_tick();
    end
    check("b_wu_pulses", wu_pulses, 2);
    check("b_wu_value", wu_bad, 0);
    check("b_done_cnt", done_cnt, 1);
    check("b_unmasked", unmasked_bad, 0);
    check("b_bcnt", bcnt, 16'd2);
    check("b_busy_end", busy, 1'b0);

    // Scenario C: timeout 100 with no sleep; RUN starts at cycle 9.
    go(4'hF, 16'd0, TW'(100));
    mon_clear(4'hF);
    while (cyc < 108) mon_tick();
    check("c_tmo_c108", tmo_flag, 1'b0);
    mon_tick();
    check("c_tmo_c109", tmo_flag, 1'b1);
    check("c_te_c109", te, 4'hF);
    mon_tick();
    check("c_en_c110", {te, fe, busy}, '0);
    check("c_tmo_sticky", tmo_flag, 1'b1);
    check("c_no_done", done_cnt, 0);
    go(4'hF, 16'd0, '0);
    check("c_tmo_cleared", tmo_flag, 1'b0);

    // Scenario D: abort during LAUNCH of the run just started.
    repeat (4) tick();
    check("d_fe_c5", fe, 4'h3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("d_abort_c6", {te, fe, wu, busy, done, tmo_flag, bcnt}, '0);
    tick(); tick();
    check("d_idle", {busy, te}, '0);
    run_table();

    // Scenario E: empty mask completes at once.
    go(4'h0, 16'd0, '0);
    check("e_done_c1", done, 1'b1);
    check("e_te_c1", {te, busy}, '0);
    tick();
    check("e_done_c2", done, 1'b0);

    // Scenario F: single-cycle sleep is not a barrier.
    go(4'hF, 16'd0, '0);
    while (cyc < 12) tick();
    sleep = 4'hF;
    tick();
    sleep = 4'h0;
    mon_clear(4'hF);
    repeat (10) mon_tick();
    check("f_glitch_wu", wu_pulses, 0);
    check("f_glitch_done", done_cnt, 0);
    check("f_glitch_busy", busy, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // Scenario F2: sleep held across the guard window is ignored.
    go(4'hF, 16'd1, '0);
    while (cyc < 12) tick();
    sleep = 4'hF;
    tick(); tick();
    check("f2_wu_c14", wu, 4'hF);
    check("f2_bcnt_c14", bcnt, 16'd1);
    mon_clear(4'hF);
    mon_tick(); mon_tick(); mon_tick();
    sleep = 4'h0;
    repeat (10) mon_tick();
    check("f2_guard_wu", wu_pulses, 0);
    check("f2_guard_done", done_cnt, 0);
    sleep = 4'hF;
    mon_tick(); mon_tick();
    sleep = 4'h0;
    mon_tick(); mon_tick();
    check("f2_final_done", done_cnt, 1);

    // Random traffic against the reference model.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    model_on = 1'b1;
    cyc = 0;
    sleep_hold = 0;
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 19) == 0);
      abort = ($urandom_range(0, 199) == 0);
      mask  = N'($urandom_range(0, 15));
      nb    = 16'($urandom_range(0, 3));
      tmo   = ($urandom_range(0, 2) == 0) ? '0 : TW'($urandom_range(4, 40));
      if (sleep_hold == 0) begin
        sleep      = ($urandom_range(0, 9) < 4) ? 4'hF : N'($urandom_range(0, 15));
        sleep_hold = $urandom_range(1, 3);
      end
      sleep_hold--;
      tick();
      check("rand_cycle", {te, fe, wu, busy, done, tmo_flag, bcnt},
            {e_te, e_fe, e_wu, e_busy, e_done, e_tmo, e_cnt});
    end
    model_on = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
    $fatal(1);
  end

endmodule
